// File: rtl/mimo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mimo_pkg
//  Description : Shared constants and types for the MIMO frame sequencer.
//                N_ANT channel rows make one channel matrix; each FIFO word is
//                {flag, payload}. The flag tells the detector whether the
//                payload is a channel row (FLAG_CH) or a data vector
//                (FLAG_DATA).
//  Revision    : 1.0 - initial release
// ============================================================================
package mimo_pkg;

    localparam int N_ANT   = 4;
    localparam int I_WIDTH = 16;
    localparam int D_WIDTH = I_WIDTH * N_ANT * 2;

    localparam logic FLAG_CH   = 1'b1;
    localparam logic FLAG_DATA = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_H = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mimo_seq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mimo_seq_fifo
//  Description : Synchronous first-word-fall-through FIFO. The oldest entry is
//                always visible on head while the FIFO is not empty.
//                A push is accepted when full if a pop happens in the same cycle.
//  Ports       : clk, rst_n     clock / async active-low reset
//                push, push_data write side
//                pop             consume head (ignored when empty)
//                head            oldest entry
//                empty, full     occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module mimo_seq_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_DEPTH);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign head      = r_mem[r_rd_ptr];

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mimo_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mimo_frame_sequencer
//  Description : Buffers tagged words for the MIMO detector, enforces frame
//                order (N_ANT channel rows, then data vectors), throttles on
//                the detector's ready, and drains in-flight detections before
//                a new channel matrix is loaded.
//  Ports       : clk, rst_n                 clock / async active-low reset
//                s_valid/s_ready/s_flag/s_data   upstream push interface
//                m_in_valid/m_flag/m_data/m_in_ready  detector issue interface
//                det_out_valid               one detector result per pulse
//                outstanding                 data vectors in flight
//                frame_done                  previous frame fully answered
//                err_no_channel, err_underflow  sticky error flags
//                drop_cnt                    discarded data words (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module mimo_frame_sequencer
    import mimo_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic                                 s_flag,
    input  logic [D_WIDTH-1:0]                   s_data,
    output logic                                 m_in_valid,
    output logic                                 m_flag,
    output logic [D_WIDTH-1:0]                   m_data,
    input  logic                                 m_in_ready,
    input  logic                                 det_out_valid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 frame_done,
    output logic                                 err_no_channel,
    output logic                                 err_underflow,
    output logic [7:0]                           drop_cnt
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int ROW_W = (N_ANT > 1) ? $clog2(N_ANT) : 1;
    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(N_ANT - 1);
    localparam logic [OUT_W-1:0] c_MAX_OUT  = OUT_W'(MAX_OUTSTANDING);

    seq_state_t         r_state;
    logic [ROW_W-1:0]   r_row_cnt;
    logic [OUT_W-1:0]   r_outstanding;
    logic               r_alive;
    logic               r_frame_done;
    logic               r_err_no_channel;
    logic               r_err_underflow;
    logic [7:0]         r_drop_cnt;

    logic [D_WIDTH:0]   w_head;
    logic               w_head_flag;
    logic               w_empty;
    logic               w_full;
    logic               w_allow;
    logic               w_drop;
    logic               w_xfer;
    logic               w_data_xfer;
    logic               w_pop;
    logic               w_push;

    mimo_seq_fifo #(
        .WIDTH (D_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data ({s_flag, s_data}),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full)
    );

    assign w_head_flag = w_head[D_WIDTH];

    // Decide, per state, whether the head may go to the detector or must be
    // discarded. Channel heads in IDLE/STREAM only steer the FSM.
    always_comb begin
        w_allow = 1'b0;
        w_drop  = 1'b0;
        if (!w_empty) begin
            case (r_state)
                IDLE:   w_drop  = (w_head_flag == FLAG_DATA);
                LOAD_H: begin
                    w_allow = (w_head_flag == FLAG_CH);
                    w_drop  = (w_head_flag == FLAG_DATA);
                end
                STREAM: w_allow = (w_head_flag == FLAG_DATA) && (r_outstanding < c_MAX_OUT);
                DRAIN:  w_allow = 1'b0;
            endcase
        end
    end

    // Valid is only raised while the detector is ready, so a raised valid is
    // always a completed transfer.
    assign w_xfer      = w_allow & m_in_ready;
    assign w_data_xfer = w_xfer & (w_head_flag == FLAG_DATA);
    assign w_pop       = w_xfer | w_drop;
    // Ready depends on the pop decision (never on s_valid) so a full FIFO can
    // take a word in the same cycle it releases one.
    assign s_ready     = r_alive & (~w_full | w_pop);
    assign w_push      = s_valid & s_ready;

    assign m_in_valid     = w_xfer;
    assign m_flag         = w_head_flag;
    assign m_data         = w_head[D_WIDTH-1:0];
    assign outstanding    = r_outstanding;
    assign frame_done     = r_frame_done;
    assign err_no_channel = r_err_no_channel;
    assign err_underflow  = r_err_underflow;
    assign drop_cnt       = r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_row_cnt        <= '0;
            r_outstanding    <= '0;
            r_alive          <= 1'b0;
            r_frame_done     <= 1'b0;
            r_err_no_channel <= 1'b0;
            r_err_underflow  <= 1'b0;
            r_drop_cnt       <= '0;
        end else begin
            r_alive      <= 1'b1;
            r_frame_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!w_empty && (w_head_flag == FLAG_CH)) begin
                        r_state   <= LOAD_H;
                        r_row_cnt <= '0;
                    end
                end
                LOAD_H: begin
                    if (w_xfer) begin
                        if (r_row_cnt == c_LAST_ROW) begin
                            r_state   <= STREAM;
                            r_row_cnt <= '0;
                        end else begin
                            r_row_cnt <= r_row_cnt + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    // A new matrix must wait until every pending result is back.
                    if (!w_empty && (w_head_flag == FLAG_CH)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_frame_done <= 1'b1;
                        r_state      <= LOAD_H;
                        r_row_cnt    <= '0;
                    end
                end
            endcase

            if (w_drop && (r_state == IDLE)) begin
                r_err_no_channel <= 1'b1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end

            // Simultaneous issue and result cancel out.
            if (w_data_xfer && !det_out_valid) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!w_data_xfer && det_out_valid) begin
                if (r_outstanding == '0) begin
                    r_err_underflow <= 1'b1;
                end else begin
                    r_outstanding <= r_outstanding - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
